alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arb_pkg.sv | 36 +++
 rtl/alu_arbiter_alu.sv | 61 ++++++
 rtl/alu_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states,
// flag bit positions and the legal-op check.
package alu_arb_pkg;

    localparam int ARB_DATA_W = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1101;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_SIGN  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB) || (sel == OP_OR)  ||
               (sel == OP_AND) || (sel == OP_XOR) || (sel == OP_SLL) ||
               (sel == OP_SRL) || (sel == OP_SRA) || (sel == OP_SLT) ||
               (sel == OP_SLTU);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU; flags always come from its adder (A+B, or A-B for the
// subtract/compare ops). Unknown selects fall through to A+B.
module alu_arbiter_alu
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        sel_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic                     is_sub;
    logic [DATA_W-1:0]        b_eff;
    logic [DATA_W:0]          sum_w;
    logic                     carry;
    logic                     ovf;
    logic                     lt_s;
    logic                     lt_u;
    logic [SH_W-1:0]          shamt;
    logic signed [DATA_W-1:0] sra_w;

    assign is_sub = (sel_i == OP_SUB) || (sel_i == OP_SLT) || (sel_i == OP_SLTU);
    assign b_eff  = is_sub ? ~b_i : b_i;
    assign sum_w  = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
    assign carry  = sum_w[DATA_W];
    assign ovf    = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum_w[DATA_W-1] != a_i[DATA_W-1]);
    // Compares reuse the subtractor: signed from sign^overflow, unsigned from borrow.
    assign lt_s   = sum_w[DATA_W-1] ^ ovf;
    assign lt_u   = ~carry;
    assign shamt  = b_i[SH_W-1:0];
    assign sra_w  = $signed(a_i) >>> shamt;

    always_comb begin
        result_o = sum_w[DATA_W-1:0];
        case (sel_i)
            OP_OR:   result_o = a_i | b_i;
            OP_AND:  result_o = a_i & b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = sra_w;
            OP_SLT:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
            OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, lt_u};
            default: result_o = sum_w[DATA_W-1:0];
        endcase
    end

    always_comb begin
        flags_o             = '0;
        flags_o[FLAG_ZERO]  = (sum_w[DATA_W-1:0] == '0);
        flags_o[FLAG_CARRY] = carry;
        flags_o[FLAG_OVF]   = ovf;
        flags_o[FLAG_SIGN]  = sum_w[DATA_W-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through an IDLE -> EXEC -> RESP FSM with a
// round-robin priority pointer; one operation completes every three cycles at best.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic [ARB_DATA_W-1:0] req_a_0,
    input  logic [ARB_DATA_W-1:0] req_b_0,
    input  logic [3:0]            req_sel_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic [ARB_DATA_W-1:0] req_a_1,
    input  logic [ARB_DATA_W-1:0] req_b_1,
    input  logic [3:0]            req_sel_1,
    output logic                  resp_valid_0,
    input  logic                  resp_ready_0,
    output logic [ARB_DATA_W-1:0] resp_result_0,
    output logic [3:0]            resp_flags_0,
    output logic                  resp_err_0,
    output logic                  resp_valid_1,
    input  logic                  resp_ready_1,
    output logic [ARB_DATA_W-1:0] resp_result_1,
    output logic [3:0]            resp_flags_1,
    output logic                  resp_err_1,
    output logic [15:0]           op_count
);

    state_e                state_q;
    logic                  ptr_q;
    logic                  owner_q;
    logic [1:0]            resp_valid_q;
    logic [ARB_DATA_W-1:0] result_q;
    logic [3:0]            flags_q;
    logic                  err_q;
    logic [15:0]           op_count_q;
    logic [15:0]           op_count_d;

    logic [ARB_DATA_W-1:0] a_q;
    logic [ARB_DATA_W-1:0] b_q;
    logic [3:0]            sel_q;

    logic                  gnt_0;
    logic                  gnt_1;
    logic                  resp_hs;
    logic [ARB_DATA_W-1:0] alu_result;
    logic [3:0]            alu_flags;

    // Pointer only matters when both ask; a lone requester always wins.
    assign gnt_0      = (state_q == ST_IDLE) && req_valid_0 && (!req_valid_1 || !ptr_q);
    assign gnt_1      = (state_q == ST_IDLE) && req_valid_1 && (!req_valid_0 ||  ptr_q);
    assign resp_hs    = (state_q == ST_RESP) && (owner_q ? resp_ready_1 : resp_ready_0);
    assign op_count_d = op_count_q + 16'd1;

    assign req_ready_0 = gnt_0 && rst_n;
    assign req_ready_1 = gnt_1 && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 1'b0;
            owner_q      <= 1'b0;
            resp_valid_q <= 2'b00;
            result_q     <= '0;
            flags_q      <= '0;
            err_q        <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_0 || gnt_1) begin
                        owner_q <= gnt_1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q     <= alu_result;
                    flags_q      <= alu_flags;
                    err_q        <= !op_is_legal(sel_q);
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    // Returning through IDLE keeps a grant out of the handshake cycle.
                    if (resp_hs) begin
                        resp_valid_q <= 2'b00;
                        ptr_q        <= !owner_q;
                        op_count_q   <= op_count_d;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_0 || gnt_1) begin
            a_q   <= gnt_1 ? req_a_1   : req_a_0;
            b_q   <= gnt_1 ? req_b_1   : req_b_0;
            sel_q <= gnt_1 ? req_sel_1 : req_sel_0;
        end
    end

    alu_arbiter_alu #(
        .DATA_W (ARB_DATA_W)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .sel_i    (sel_q),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    assign resp_valid_0  = resp_valid_q[0];
    assign resp_valid_1  = resp_valid_q[1];
    assign resp_result_0 = result_q;
    assign resp_result_1 = result_q;
    assign resp_flags_0  = flags_q;
    assign resp_flags_1  = flags_q;
    assign resp_err_0    = err_q;
    assign resp_err_1    = err_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level reference model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic [3:0]  req_sel_0 = '0, req_sel_1 = '0;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0 = 1'b0, resp_ready_1 = 1'b0;
    logic [31:0] resp_result_0, resp_result_1;
    logic [3:0]  resp_flags_0, resp_flags_1;
    logic        resp_err_0, resp_err_1;
    logic [15:0] op_count;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_sel_0(req_sel_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_sel_1(req_sel_1),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0),
        .resp_result_0(resp_result_0), .resp_flags_0(resp_flags_0), .resp_err_0(resp_err_0),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1),
        .resp_result_1(resp_result_1), .resp_flags_1(resp_flags_1), .resp_err_1(resp_err_1),
        .op_count(op_count)
    );

    function automatic logic [31:0] ref_result(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h4: return a | b;
            4'h5: return a & b;
            4'h7: return a ^ b;
            4'h8: return a << b[4:0];
            4'h9: return a >> b[4:0];
            4'hA: return 32'($signed(a) >>> b[4:0]);
            4'hD: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'hF: return (a < b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] ref_flags(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  f;
        logic [32:0] wide;
        logic [31:0] r;
        f = '0;
        if (s == 4'h1 || s == 4'hD || s == 4'hF) begin
            r    = a - b;
            f[1] = (a >= b);
            f[2] = (a[31] != b[31]) && (r[31] != a[31]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            f[1] = wide[32];
            f[2] = (a[31] == b[31]) && (r[31] != a[31]);
        end
        f[0] = (r == 32'd0);
        f[3] = r[31];
        return f;
    endfunction

    function automatic logic ref_illegal(input logic [3:0] s);
        return !(s inside {4'h0, 4'h1, 4'h4, 4'h5, 4'h7, 4'h8, 4'h9, 4'hA, 4'hD, 4'hF});
    endfunction

    function automatic logic pick(input logic v0, input logic v1, input logic p);
        return (v0 && v1) ? p : v1;
    endfunction

    // Reference model: phase 0 free, 1 computing, 2 response pending.
    int          m_phase;
    logic        m_ptr, m_own, m_err;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_sel, m_flg;
    logic [15:0] m_done;
    logic [15:0] m_base = 16'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_ptr <= 1'b0; m_own <= 1'b0; m_done <= '0;
            m_res <= '0; m_flg <= '0; m_err <= 1'b0;
        end else begin
            case (m_phase)
                0: if (req_valid_0 || req_valid_1) begin
                    m_own   <= pick(req_valid_0, req_valid_1, m_ptr);
                    m_a     <= pick(req_valid_0, req_valid_1, m_ptr) ? req_a_1 : req_a_0;
                    m_b     <= pick(req_valid_0, req_valid_1, m_ptr) ? req_b_1 : req_b_0;
                    m_sel   <= pick(req_valid_0, req_valid_1, m_ptr) ? req_sel_1 : req_sel_0;
                    m_phase <= 1;
                end
                1: begin
                    m_res   <= ref_result(m_sel, m_a, m_b);
                    m_flg   <= ref_flags(m_sel, m_a, m_b);
                    m_err   <= ref_illegal(m_sel);
                    m_phase <= 2;
                end
                default: if (m_own ? resp_ready_1 : resp_ready_0) begin
                    m_phase <= 0;
                    m_done  <= m_done + 16'd1;
                    m_ptr   <= !m_own;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        logic e_rdy0, e_rdy1, e_rv0, e_rv1;
        e_rdy0 = rst_n && (m_phase == 0) && req_valid_0 && (!req_valid_1 || !m_ptr);
        e_rdy1 = rst_n && (m_phase == 0) && req_valid_1 && (!req_valid_0 ||  m_ptr);
        e_rv0  = rst_n && (m_phase == 2) && !m_own;
        e_rv1  = rst_n && (m_phase == 2) &&  m_own;
        chk("req_ready_0", 32'(req_ready_0), 32'(e_rdy0));
        chk("req_ready_1", 32'(req_ready_1), 32'(e_rdy1));
        chk("resp_valid_0", 32'(resp_valid_0), 32'(e_rv0));
        chk("resp_valid_1", 32'(resp_valid_1), 32'(e_rv1));
        chk("op_count", 32'(op_count), 32'(16'(m_base + m_done)));
        if (!rst_n) begin
            chk("rst_result", resp_result_0 | resp_result_1, 32'd0);
            chk("rst_flags_err", 32'({resp_flags_0, resp_flags_1, resp_err_0, resp_err_1}), 32'd0);
        end
        if (e_rv0) begin
            chk("resp_result_0", resp_result_0, m_res);
            chk("resp_flags_0", 32'(resp_flags_0), 32'(m_flg));
            chk("resp_err_0", 32'(resp_err_0), 32'(m_err));
        end
        if (e_rv1) begin
            chk("resp_result_1", resp_result_1, m_res);
            chk("resp_flags_1", 32'(resp_flags_1), 32'(m_flg));
            chk("resp_err_1", 32'(resp_err_1), 32'(m_err));
        end
    endtask

    task automatic half(); @(negedge clk); compare_all(); endtask
    task automatic rise(); @(posedge clk); #1; endtask
    task automatic cyc();  half(); rise(); endtask

    task automatic do_op(input logic who, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_res, input logic [3:0] e_flg, input logic e_err);
        bit got, done;
        int lat;
        got = 0; done = 0; lat = 0;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        if (who) begin req_a_1 = a; req_b_1 = b; req_sel_1 = s; req_valid_1 = 1'b1; end
        else     begin req_a_0 = a; req_b_0 = b; req_sel_0 = s; req_valid_0 = 1'b1; end
        for (int i = 0; i < 8 && !got; i++) begin
            half();
            if (who ? req_ready_1 : req_ready_0) got = 1;
            rise();
        end
        if (who) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
        chk("op_accept", 32'(got), 32'd1);
        for (int i = 0; i < 8 && !done; i++) begin
            half();
            lat++;
            if (who ? resp_valid_1 : resp_valid_0) begin
                done = 1;
                chk("op_result", who ? resp_result_1 : resp_result_0, e_res);
                chk("op_flags", 32'(who ? resp_flags_1 : resp_flags_0), 32'(e_flg));
                chk("op_err", 32'(who ? resp_err_1 : resp_err_0), 32'(e_err));
                chk("op_latency", 32'(lat), 32'd2);
            end
            rise();
        end
        chk("op_response", 32'(done), 32'd1);
    endtask

    typedef struct {
        logic        who;
        logic [3:0]  s;
        logic [31:0] a, b, res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    vec_t vecs[12] = '{
        '{1'b0, 4'h4, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 4'b1000, 1'b0},
        '{1'b1, 4'h5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0010, 1'b0},
        '{1'b0, 4'h7, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 4'b1010, 1'b0},
        '{1'b1, 4'h8, 32'h0000_0001, 32'd31,        32'h8000_0000, 4'b0000, 1'b0},
        '{1'b0, 4'h9, 32'h8000_0000, 32'd4,         32'h0800_0000, 4'b1000, 1'b0},
        '{1'b1, 4'hA, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000, 1'b0},
        '{1'b0, 4'hD, 32'hFFFF_FFFF, 32'd1,         32'd1,         4'b1010, 1'b0},
        '{1'b1, 4'hF, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b1010, 1'b0},
        '{1'b0, 4'h0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1100, 1'b0},
        '{1'b1, 4'h0, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0011, 1'b0},
        '{1'b0, 4'h1, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000, 1'b0},
        '{1'b1, 4'hE, 32'd1,         32'd2,         32'd3,         4'b0000, 1'b1}
    };

    initial begin
        #1 rst_n = 1'b0;
        req_valid_0 = 1'b1;
        rise();
        cyc(); cyc();
        chk("rst_ready_0", 32'(req_ready_0), 32'd0);
        req_valid_0 = 1'b0;
        rst_n = 1'b1;
        cyc();

        // Single ADD 5+7 from requester 0
        req_valid_0 = 1'b1; req_a_0 = 32'd5; req_b_0 = 32'd7; req_sel_0 = 4'h0; resp_ready_0 = 1'b1;
        half(); chk("add_ready_0", 32'(req_ready_0), 32'd1); chk("add_ready_1", 32'(req_ready_1), 32'd0); rise();
        req_valid_0 = 1'b0;
        half(); chk("add_valid_early", 32'(resp_valid_0), 32'd0); rise();
        half();
        chk("add_valid", 32'(resp_valid_0), 32'd1);
        chk("add_result", resp_result_0, 32'd12);
        chk("add_flags", 32'(resp_flags_0), 32'd0);
        chk("add_err", 32'(resp_err_0), 32'd0);
        rise();
        half(); chk("add_count", 32'(op_count), 32'd1); rise();

        // Simultaneous requests right after reset
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        req_valid_0 = 1'b1; req_a_0 = 32'd3; req_b_0 = 32'd3; req_sel_0 = 4'h1;
        req_valid_1 = 1'b1; req_a_1 = 32'd1; req_b_1 = 32'd2; req_sel_1 = 4'hF;
        resp_ready_0 = 1'b1; resp_ready_1 = 1'b1;
        half(); chk("both_ready_0", 32'(req_ready_0), 32'd1); chk("both_ready_1", 32'(req_ready_1), 32'd0); rise();
        req_valid_0 = 1'b0;
        cyc();
        half();
        chk("sub_result", resp_result_0, 32'd0);
        chk("sub_zero", 32'(resp_flags_0[0]), 32'd1);
        chk("sub_hs_ready_1", 32'(req_ready_1), 32'd0);
        rise();
        half(); chk("sltu_ready_1", 32'(req_ready_1), 32'd1); rise();
        req_valid_1 = 1'b0;
        cyc();
        half(); chk("sltu_valid", 32'(resp_valid_1), 32'd1); chk("sltu_result", resp_result_1, 32'd1); rise();

        // Pointer back at requester 0, then hold its response under backpressure
        req_valid_0 = 1'b1; req_a_0 = 32'd10;  req_b_0 = 32'd20; req_sel_0 = 4'h0;
        req_valid_1 = 1'b1; req_a_1 = 32'd100; req_b_1 = 32'd1;  req_sel_1 = 4'h0;
        resp_ready_0 = 1'b0;
        half(); chk("ptr_end_ready_0", 32'(req_ready_0), 32'd1); chk("ptr_end_ready_1", 32'(req_ready_1), 32'd0); rise();
        req_valid_0 = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            half();
            chk("bp_valid", 32'(resp_valid_0), 32'd1);
            chk("bp_result", resp_result_0, 32'd30);
            chk("bp_ready_1", 32'(req_ready_1), 32'd0);
            rise();
        end
        resp_ready_0 = 1'b1;
        half(); chk("bp_hs_ready_1", 32'(req_ready_1), 32'd0); rise();
        half(); chk("bp_idle_ready_1", 32'(req_ready_1), 32'd1); rise();
        req_valid_1 = 1'b0;
        cyc();
        half(); chk("bp_r1_result", resp_result_1, 32'd101); rise();

        foreach (vecs[i])
            do_op(vecs[i].who, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].err);

        // Reset while requester 0's op is executing and requester 1 waits
        req_valid_0 = 1'b1; req_a_0 = 32'd4; req_b_0 = 32'd4; req_sel_0 = 4'h0;
        half(); chk("rx_ready_0", 32'(req_ready_0), 32'd1); rise();
        req_valid_1 = 1'b1; req_a_1 = 32'd1; req_b_1 = 32'd2; req_sel_1 = 4'h4;
        rst_n = 1'b0;
        half();
        chk("rx_valid", 32'({resp_valid_0, resp_valid_1}), 32'd0);
        chk("rx_ready", 32'({req_ready_0, req_ready_1}), 32'd0);
        chk("rx_count", 32'(op_count), 32'd0);
        rise();
        cyc();
        rst_n = 1'b1;
        half(); chk("rx_rel_ready_0", 32'(req_ready_0), 32'd1); chk("rx_rel_ready_1", 32'(req_ready_1), 32'd0); rise();
        req_valid_0 = 1'b0;
        cyc(); cyc();
        half(); chk("rx_r1_ready", 32'(req_ready_1), 32'd1); rise();
        req_valid_1 = 1'b0;
        cyc(); cyc();
        half(); chk("rx_count_after", 32'(op_count), 32'd2); rise();

        // Preload the completion counter just below wrap
        m_base = 16'hFFFE - m_done;
        force dut.op_count_q = 16'hFFFE;
        cyc(); cyc();
        release dut.op_count_q;
        half(); chk("wrap_preload", 32'(op_count), 32'h0000_FFFE); rise();
        do_op(1'b0, 4'h0, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0);
        do_op(1'b1, 4'h0, 32'd2, 32'd2, 32'd4, 4'b0000, 1'b0);
        half(); chk("wrap_zero", 32'(op_count), 32'd0); rise();
        do_op(1'b0, 4'h5, 32'd6, 32'd3, 32'd2, 4'b0000, 1'b0);
        half(); chk("wrap_one", 32'(op_count), 32'd1); rise();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
